ucode_issue_ctrl: RTL and testbench

UCODE_ISSUE_CTRL -- requirements
Module: ucode_issue_ctrl

---
 rtl/ucode_issue_ctrl_pkg.sv | 38 +++
 rtl/ucode_issue_ctrl_watchdog.sv | 38 +++
 rtl/ucode_issue_ctrl.sv | 138 +++++++++++++
 tb/tb_ucode_issue_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ucode_issue_ctrl_pkg.sv
// Shared definitions for the microcoded-MUL issue path: state encoding,
// pipeline no-op, MUL type codes and the latched operand bundle.
package ucode_issue_ctrl_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned REG_W   = 4;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned FLAGS_W = 4;
  localparam int unsigned WD_W    = 16;

  localparam logic [INSTR_W-1:0] UC_NOP_INSTR = {5'b11001, 27'b0};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_RUN     = 3'd2,
    ST_RESTORE = 3'd3,
    ST_ABORT   = 3'd4
  } issue_state_e;

  typedef enum logic [1:0] {
    MUL_MULI  = 2'd0,
    MUL_MULR  = 2'd1,
    MUL_MULSI = 2'd2,
    MUL_MULSR = 2'd3
  } mul_type_e;

  typedef struct packed {
    logic [REG_W-1:0]   dest_reg;
    logic [REG_W-1:0]   source_reg;
    logic [IMM_W-1:0]   immediate;
    logic [DATA_W-1:0]  read_data_second;
    mul_type_e          mul_type;
    logic [FLAGS_W-1:0] flags;
  } mul_op_t;

endpackage

// File: rtl/ucode_issue_ctrl_watchdog.sv
// Saturating cycle counter for the RUN phase; hit flags the last allowed cycle.
module ucode_watchdog
  import ucode_issue_ctrl_pkg::*;
#(
  parameter logic [WD_W-1:0] TIMEOUT = 16'd1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear_i,
  input  logic            enable_i,
  output logic [WD_W-1:0] count_o,
  output logic            hit_o
);

  logic [WD_W-1:0] count_q;
  logic [WD_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != '1)) begin
      count_d = count_q + WD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign hit_o   = (count_q == (TIMEOUT - WD_W'(1)));

endmodule

// File: rtl/ucode_issue_ctrl.sv
// Hands decoded MULs to the microcode sequencer, stalls fetch while it runs,
// muxes its instructions into the pipe and restores flags afterwards.
module ucode_issue_ctrl
  import ucode_issue_ctrl_pkg::*;
#(
  parameter logic [WD_W-1:0]    TIMEOUT   = 16'd1024,
  parameter logic [INSTR_W-1:0] NOP_INSTR = UC_NOP_INSTR
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [INSTR_W-1:0]  if_instruction,
  input  logic                if_valid,
  input  logic                id_is_mul,
  input  logic [REG_W-1:0]    id_dest_reg,
  input  logic [REG_W-1:0]    id_source_reg,
  input  logic [IMM_W-1:0]    id_immediate,
  input  logic [DATA_W-1:0]   id_read_data_second,
  input  logic [1:0]          id_mul_type,
  input  logic [FLAGS_W-1:0]  ex_flags,
  input  logic [INSTR_W-1:0]  uc_instruction,
  input  logic                uc_mux_ctrl,
  input  logic                uc_mul_release,
  input  logic [FLAGS_W-1:0]  uc_flags_back,
  output logic                start_mul,
  output logic [REG_W-1:0]    dest_reg,
  output logic [REG_W-1:0]    source_reg,
  output logic [IMM_W-1:0]    immediate,
  output logic [DATA_W-1:0]   read_data_second,
  output logic [1:0]          mul_type,
  output logic [FLAGS_W-1:0]  flags_to_uc,
  output logic [INSTR_W-1:0]  issue_instruction,
  output logic                pc_stall,
  output logic                id_flush,
  output logic                flags_restore_valid,
  output logic [FLAGS_W-1:0]  flags_restore,
  output logic                busy,
  output logic                timeout_err
);

  issue_state_e    state_q;
  mul_op_t         op_q;
  mul_op_t         op_d;
  logic            timeout_err_q;
  logic            mul_take;
  logic            run_expired;
  logic [WD_W-1:0] wd_count;
  logic            wd_hit;

  assign mul_take = id_is_mul && if_valid;

  assign op_d = '{dest_reg:         id_dest_reg,
                  source_reg:       id_source_reg,
                  immediate:        id_immediate,
                  read_data_second: id_read_data_second,
                  mul_type:         mul_type_e'(id_mul_type),
                  flags:            ex_flags};

  ucode_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (state_q != ST_RUN),
    .enable_i (state_q == ST_RUN),
    .count_o  (wd_count),
    .hit_o    (wd_hit)
  );

  // A zero budget still grants the first RUN cycle before aborting.
  assign run_expired = wd_hit || ((TIMEOUT == '0) && (wd_count == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      op_q          <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mul_take) begin
            op_q    <= op_d;
            state_q <= ST_START;
          end
        end
        ST_START: state_q <= ST_RUN;
        ST_RUN: begin
          if (uc_mul_release) begin
            state_q <= ST_RESTORE;
          end else if (run_expired) begin
            state_q <= ST_ABORT;
          end
        end
        ST_RESTORE: state_q <= ST_IDLE;
        ST_ABORT: begin
          timeout_err_q <= 1'b1;
          state_q       <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Pipe-facing controls decode from state so the flush/stall hit the MUL's own cycle.
  always_comb begin
    start_mul           = 1'b0;
    pc_stall            = 1'b1;
    id_flush            = 1'b0;
    flags_restore_valid = 1'b0;
    flags_restore       = '0;
    issue_instruction   = NOP_INSTR;
    case (state_q)
      ST_IDLE: begin
        pc_stall          = mul_take;
        id_flush          = mul_take;
        issue_instruction = if_valid ? if_instruction : NOP_INSTR;
      end
      ST_START: start_mul = 1'b1;
      ST_RUN:   issue_instruction = uc_mux_ctrl ? uc_instruction : NOP_INSTR;
      ST_RESTORE: begin
        flags_restore_valid = 1'b1;
        flags_restore       = uc_flags_back;
      end
      ST_ABORT: begin
        flags_restore_valid = 1'b1;
        flags_restore       = op_q.flags;
      end
      default: ;
    endcase
  end

  assign dest_reg         = op_q.dest_reg;
  assign source_reg       = op_q.source_reg;
  assign immediate        = op_q.immediate;
  assign read_data_second = op_q.read_data_second;
  assign mul_type         = op_q.mul_type;
  assign flags_to_uc      = op_q.flags;
  assign busy             = (state_q != ST_IDLE);
  assign timeout_err      = timeout_err_q;

endmodule

// File: tb/tb_ucode_issue_ctrl.sv
// Directed bench: default-timeout instance (a) for release/rst flows,
// TIMEOUT=4 instance (b) for watchdog abort and release-vs-hit.
module tb_ucode_issue_ctrl;

  localparam logic [31:0] NOP = 32'hC800_0000;

  logic        clk, rst;
  logic [31:0] if_instruction;
  logic        if_valid, id_is_mul;
  logic [3:0]  id_dest_reg, id_source_reg;
  logic [15:0] id_immediate;
  logic [31:0] id_read_data_second;
  logic [1:0]  id_mul_type;
  logic [3:0]  ex_flags;
  logic [31:0] uc_instruction;
  logic        uc_mux_ctrl, uc_mul_release;
  logic [3:0]  uc_flags_back;

  logic        a_start_mul, a_pc_stall, a_id_flush, a_frv, a_busy, a_terr;
  logic [3:0]  a_dest, a_src, a_flags_uc, a_flags_rs;
  logic [15:0] a_imm;
  logic [31:0] a_rdata, a_issue;
  logic [1:0]  a_type;

  logic        b_start_mul, b_pc_stall, b_id_flush, b_frv, b_busy, b_terr;
  logic [3:0]  b_dest, b_src, b_flags_uc, b_flags_rs;
  logic [15:0] b_imm;
  logic [31:0] b_rdata, b_issue;
  logic [1:0]  b_type;

  int n_tests;
  int n_fail;

  ucode_issue_ctrl dut_a (
    .clk(clk), .rst(rst), .if_instruction(if_instruction), .if_valid(if_valid),
    .id_is_mul(id_is_mul), .id_dest_reg(id_dest_reg), .id_source_reg(id_source_reg),
    .id_immediate(id_immediate), .id_read_data_second(id_read_data_second),
    .id_mul_type(id_mul_type), .ex_flags(ex_flags), .uc_instruction(uc_instruction),
    .uc_mux_ctrl(uc_mux_ctrl), .uc_mul_release(uc_mul_release), .uc_flags_back(uc_flags_back),
    .start_mul(a_start_mul), .dest_reg(a_dest), .source_reg(a_src), .immediate(a_imm),
    .read_data_second(a_rdata), .mul_type(a_type), .flags_to_uc(a_flags_uc),
    .issue_instruction(a_issue), .pc_stall(a_pc_stall), .id_flush(a_id_flush),
    .flags_restore_valid(a_frv), .flags_restore(a_flags_rs), .busy(a_busy), .timeout_err(a_terr)
  );

  ucode_issue_ctrl #(.TIMEOUT(16'd4)) dut_b (
    .clk(clk), .rst(rst), .if_instruction(if_instruction), .if_valid(if_valid),
    .id_is_mul(id_is_mul), .id_dest_reg(id_dest_reg), .id_source_reg(id_source_reg),
    .id_immediate(id_immediate), .id_read_data_second(id_read_data_second),
    .id_mul_type(id_mul_type), .ex_flags(ex_flags), .uc_instruction(uc_instruction),
    .uc_mux_ctrl(uc_mux_ctrl), .uc_mul_release(uc_mul_release), .uc_flags_back(uc_flags_back),
    .start_mul(b_start_mul), .dest_reg(b_dest), .source_reg(b_src), .immediate(b_imm),
    .read_data_second(b_rdata), .mul_type(b_type), .flags_to_uc(b_flags_uc),
    .issue_instruction(b_issue), .pc_stall(b_pc_stall), .id_flush(b_id_flush),
    .flags_restore_valid(b_frv), .flags_restore(b_flags_rs), .busy(b_busy), .timeout_err(b_terr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow settle().
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic clear_inputs();
    if_instruction = '0; if_valid = 1'b0; id_is_mul = 1'b0;
    id_dest_reg = '0; id_source_reg = '0; id_immediate = '0;
    id_read_data_second = '0; id_mul_type = '0; ex_flags = '0;
    uc_instruction = '0; uc_mux_ctrl = 1'b0; uc_mul_release = 1'b0; uc_flags_back = '0;
  endtask

  task automatic issue_mul(input logic [3:0] d, input logic [3:0] s, input logic [15:0] imm,
                           input logic [31:0] rd, input logic [1:0] t, input logic [3:0] fl);
    if_valid = 1'b1; id_is_mul = 1'b1; if_instruction = 32'h0810_0003;
    id_dest_reg = d; id_source_reg = s; id_immediate = imm;
    id_read_data_second = rd; id_mul_type = t; ex_flags = fl;
  endtask

  task automatic do_reset();
    step(); rst = 1'b1; clear_inputs();
    step(); rst = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #4;
    chk("rst_start_mul", 32'(a_start_mul), 32'd0);
    chk("rst_pc_stall", 32'(a_pc_stall), 32'd0);
    chk("rst_id_flush", 32'(a_id_flush), 32'd0);
    chk("rst_frv", 32'(a_frv), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_terr", 32'(b_terr), 32'd0);
    chk("rst_dest", 32'(a_dest), 32'd0);
    chk("rst_rdata", a_rdata, 32'd0);
    chk("rst_issue_nop", a_issue, NOP);
    step(); rst = 1'b0;

    // MULI R1,R0,#3 with release five cycles after start_mul
    step();
    issue_mul(4'd1, 4'd0, 16'd3, 32'hDEAD_BEEF, 2'd0, 4'b1010);
    settle();
    chk("t1_decode_stall", 32'(a_pc_stall), 32'd1);
    chk("t1_decode_flush", 32'(a_id_flush), 32'd1);
    chk("t1_decode_nostart", 32'(a_start_mul), 32'd0);
    chk("t1_decode_issue", a_issue, 32'h0810_0003);
    step(); id_is_mul = 1'b0; if_instruction = 32'h1234_5678; ex_flags = 4'b0000; settle();
    chk("t1_start_pulse", 32'(a_start_mul), 32'd1);
    chk("t1_start_stall", 32'(a_pc_stall), 32'd1);
    chk("t1_start_issue", a_issue, NOP);
    chk("t1_dest", 32'(a_dest), 32'd1);
    chk("t1_imm", 32'(a_imm), 32'd3);
    chk("t1_rdata", a_rdata, 32'hDEAD_BEEF);
    chk("t1_flags_uc", 32'(a_flags_uc), 32'hA);
    for (int i = 0; i < 5; i++) begin
      step();
      uc_mux_ctrl = (i != 2);
      uc_instruction = 32'hA5A5_0000 + 32'(i);
      uc_mul_release = (i == 4);
      uc_flags_back = 4'b0101;
      settle();
      chk("t1_run_nostart", 32'(a_start_mul), 32'd0);
      chk("t1_run_stall", 32'(a_pc_stall), 32'd1);
      chk("t1_run_nofrv", 32'(a_frv), 32'd0);
      chk("t1_run_issue", a_issue, (i == 2) ? NOP : 32'hA5A5_0000 + 32'(i));
    end
    step(); uc_mul_release = 1'b0; uc_mux_ctrl = 1'b0; settle();
    chk("t1_restore_frv", 32'(a_frv), 32'd1);
    chk("t1_restore_flags", 32'(a_flags_rs), 32'h5);
    chk("t1_restore_stall", 32'(a_pc_stall), 32'd1);
    chk("t1_restore_issue", a_issue, NOP);
    step(); settle();
    chk("t1_idle_frv", 32'(a_frv), 32'd0);
    chk("t1_idle_stall", 32'(a_pc_stall), 32'd0);
    chk("t1_idle_busy", 32'(a_busy), 32'd0);
    chk("t1_idle_fetch", a_issue, 32'h1234_5678);
    do_reset();

    // MUL during RUN is ignored; release during START is ignored; rst in RUN
    step(); issue_mul(4'd2, 4'd3, 16'd7, 32'h11, 2'd1, 4'b0011); settle();
    chk("t2_flush", 32'(a_id_flush), 32'd1);
    step(); id_is_mul = 1'b0; uc_mul_release = 1'b1; settle();
    chk("t2_start", 32'(a_start_mul), 32'd1);
    step();
    uc_mul_release = 1'b0; id_is_mul = 1'b1; if_valid = 1'b1;
    id_dest_reg = 4'd9; id_immediate = 16'hFFFF; ex_flags = 4'b1111; id_mul_type = 2'd2;
    settle();
    chk("t2_run_nostart", 32'(a_start_mul), 32'd0);
    chk("t2_run_noflush", 32'(a_id_flush), 32'd0);
    chk("t2_run_busy", 32'(a_busy), 32'd1);
    chk("t2_start_release_ignored", 32'(a_frv), 32'd0);
    step(); settle();
    chk("t2_run2_nostart", 32'(a_start_mul), 32'd0);
    chk("t2_hold_dest", 32'(a_dest), 32'd2);
    chk("t2_hold_src", 32'(a_src), 32'd3);
    chk("t2_hold_imm", 32'(a_imm), 32'd7);
    chk("t2_hold_rdata", a_rdata, 32'h11);
    chk("t2_hold_type", 32'(a_type), 32'd1);
    chk("t2_hold_flags", 32'(a_flags_uc), 32'h3);
    step(); rst = 1'b1; id_is_mul = 1'b0; if_valid = 1'b0; settle();
    chk("t2_rst_cycle_nofrv", 32'(a_frv), 32'd0);
    step(); rst = 1'b0; settle();
    chk("t2_post_rst_start", 32'(a_start_mul), 32'd0);
    chk("t2_post_rst_stall", 32'(a_pc_stall), 32'd0);
    chk("t2_post_rst_flush", 32'(a_id_flush), 32'd0);
    chk("t2_post_rst_frv", 32'(a_frv), 32'd0);
    chk("t2_post_rst_busy", 32'(a_busy), 32'd0);
    chk("t2_post_rst_dest", 32'(a_dest), 32'd0);
    chk("t2_post_rst_imm", 32'(a_imm), 32'd0);
    chk("t2_post_rst_flags", 32'(a_flags_uc), 32'd0);
    chk("t2_post_rst_issue", a_issue, NOP);

    // TIMEOUT=4, never released: abort after four RUN cycles
    step(); issue_mul(4'd4, 4'd5, 16'h0010, 32'h2, 2'd3, 4'b0110); settle();
    chk("t3_decode_stall", 32'(b_pc_stall), 32'd1);
    step(); id_is_mul = 1'b0; if_valid = 1'b0; ex_flags = 4'b1111; settle();
    chk("t3_start", 32'(b_start_mul), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(); settle();
      chk("t3_run_busy", 32'(b_busy), 32'd1);
      chk("t3_run_nofrv", 32'(b_frv), 32'd0);
      chk("t3_run_issue", b_issue, NOP);
    end
    step(); settle();
    chk("t3_abort_frv", 32'(b_frv), 32'd1);
    chk("t3_abort_flags", 32'(b_flags_rs), 32'h6);
    chk("t3_abort_issue", b_issue, NOP);
    step(); settle();
    chk("t3_terr_set", 32'(b_terr), 32'd1);
    chk("t3_idle_frv", 32'(b_frv), 32'd0);
    chk("t3_idle_busy", 32'(b_busy), 32'd0);
    chk("t3_idle_stall", 32'(b_pc_stall), 32'd0);
    repeat (3) step();
    settle();
    chk("t3_terr_sticky", 32'(b_terr), 32'd1);
    do_reset(); settle();
    chk("t3_terr_cleared", 32'(b_terr), 32'd0);

    // Release in the same cycle the watchdog hits: restore wins
    step(); issue_mul(4'd6, 4'd7, 16'd1, 32'd3, 2'd2, 4'b0010); settle();
    step(); id_is_mul = 1'b0; if_valid = 1'b0; settle();
    chk("t4_start", 32'(b_start_mul), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(); uc_mul_release = (i == 3); uc_flags_back = 4'b1001; settle();
      chk("t4_run_nofrv", 32'(b_frv), 32'd0);
    end
    step(); uc_mul_release = 1'b0; settle();
    chk("t4_restore_frv", 32'(b_frv), 32'd1);
    chk("t4_restore_flags", 32'(b_flags_rs), 32'h9);
    step(); settle();
    chk("t4_terr_clear", 32'(b_terr), 32'd0);
    chk("t4_idle_busy", 32'(b_busy), 32'd0);
    chk("t4_idle_frv", 32'(b_frv), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
